// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory access unit.
package dmem_pkg;

  // Default data-memory size in bytes.
  localparam int unsigned DMEM_BYTES_DEFAULT = 128;

  // RV32I load/store funct3 codes. Stores only use the first three.
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  // A crossing access spends one extra cycle in BEAT2 for the upper word.
  typedef enum logic {
    IDLE  = 1'b0,
    BEAT2 = 1'b1
  } state_e;

  // Access width in bytes from the low two funct3 bits.
  // The illegal code 11 maps to 4; the fault logic suppresses it anyway.
  function automatic logic [2:0] size_bytes(input logic [1:0] f3_lo);
    logic [2:0] n;
    case (f3_lo)
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
// Works on one beat at a time. Beat 1 is the lower word. Beat 2 is the
// upper word of an access that crosses a word boundary.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_n,
  input  logic        i_sign,
  input  logic        i_beat2,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_beat0,
  output logic [3:0]  o_we,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_base;
  logic [7:0]  w_mask;
  logic [4:0]  w_shamt;
  logic [63:0] w_window;
  logic [31:0] w_lo;

  // Build the 8-lane byte mask spanning both words, then select this beat's half.
  always_comb begin
    w_base  = (8'd1 << i_n) - 8'd1;
    w_mask  = w_base << i_off;
    o_we    = i_beat2 ? w_mask[7:4] : w_mask[3:0];
    w_shamt = {i_off, 3'b000};
  end

  // Place store data in the lanes of the current beat.
  // Beat 2 carries the bytes that spilled past the word boundary.
  always_comb begin
    if (i_beat2) begin
      o_wdata = i_wdata >> (6'd32 - {1'b0, w_shamt});
    end else begin
      o_wdata = i_wdata << w_shamt;
    end
  end

  // Line up the addressed bytes at bit 0, then truncate and extend to the access width.
  // Beat 2 sees the captured lower word beneath the live upper word.
  always_comb begin
    w_window = i_beat2 ? {i_rdata, i_beat0} : {32'h0, i_rdata};
    w_lo     = 32'(w_window >> w_shamt);
    case (i_n)
      3'd1:    o_ld_data = i_sign ? {{24{w_lo[7]}}, w_lo[7:0]}
                                  : {24'h0, w_lo[7:0]};
      3'd2:    o_ld_data = i_sign ? {{16{w_lo[15]}}, w_lo[15:0]}
                                  : {16'h0, w_lo[15:0]};
      default: o_ld_data = w_lo;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory initiator. It turns load/store requests into
// word-aligned transactions. An access that crosses a word boundary is
// split into two beats, and the pipeline stalls for one cycle.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int unsigned DMEM_BYTES = DMEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  we,
  input  logic [31:0] drdata,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        stall,
  output logic        fault
);

  state_e      r_state;
  state_e      w_next;
  logic [31:0] r_beat0;
  logic        w_capture;

  logic [1:0]  w_off;
  logic [2:0]  w_n;
  logic        w_sign;
  logic        w_beat2;
  logic [31:0] w_addr0;
  logic [31:0] w_addr1;
  logic        w_cross;
  logic        w_legal;
  logic        w_fault;
  logic [3:0]  w_lane_we;
  logic [31:0] w_lane_wdata;
  logic [31:0] w_lane_ld;

  assign w_off   = req_addr[1:0];
  assign w_n     = size_bytes(req_funct3[1:0]);
  assign w_sign  = ~req_funct3[2];
  assign w_beat2 = (r_state == BEAT2);
  assign w_addr0 = {req_addr[31:2], 2'b00};
  assign w_addr1 = w_addr0 + 32'd4;
  assign w_cross = (4'(w_off) + 4'(w_n)) > 4'd4;

  // Decide which funct3 codes are legal. Unsigned sub-word codes exist only for loads.
  always_comb begin
    case (req_funct3)
      F3_B, F3_H, F3_W: w_legal = 1'b1;
      F3_BU, F3_HU:     w_legal = ~req_store;
      default:          w_legal = 1'b0;
    endcase
  end

  // Reject the whole access before any byte is written, so an overflowing store never writes partially.
  assign w_fault = ~w_legal
                 | (w_addr0 >= 32'(DMEM_BYTES))
                 | (w_cross & (w_addr1 >= 32'(DMEM_BYTES)));

  dmem_lane_align u_lane_align (
    .i_off     (w_off),
    .i_n       (w_n),
    .i_sign    (w_sign),
    .i_beat2   (w_beat2),
    .i_wdata   (req_wdata),
    .i_rdata   (drdata),
    .i_beat0   (r_beat0),
    .o_we      (w_lane_we),
    .o_wdata   (w_lane_wdata),
    .o_ld_data (w_lane_ld)
  );

  // State register and the lower-word capture used to stitch a crossing load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_beat0 <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_beat0 <= drdata;
      end
    end
  end

  // Next-state and memory-side outputs. Everything is held quiet during reset.
  // BEAT2 finishes on the held request inputs even if req_valid has dropped.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    daddr     = 32'h0;
    dwdata    = 32'h0;
    we        = 4'h0;
    ld_data   = 32'h0;
    ld_valid  = 1'b0;
    stall     = 1'b0;
    fault     = 1'b0;
    if (rst) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            if (w_fault) begin
              fault = 1'b1;
            end else begin
              daddr  = w_addr0;
              dwdata = w_lane_wdata;
              we     = req_store ? w_lane_we : 4'h0;
              if (w_cross) begin
                stall     = 1'b1;
                w_capture = 1'b1;
                w_next    = BEAT2;
              end else if (!req_store) begin
                ld_valid = 1'b1;
                ld_data  = w_lane_ld;
              end
            end
          end
        end
        BEAT2: begin
          daddr  = w_addr1;
          dwdata = w_lane_wdata;
          we     = req_store ? w_lane_we : 4'h0;
          if (!req_store) begin
            ld_valid = 1'b1;
            ld_data  = w_lane_ld;
          end
          w_next = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit. A small byte-enabled memory model
// drives drdata from daddr. Expected values are worked out by hand.
module tb_dmem_access_unit;

  logic        clk;
  logic        rst;
  logic        reqValid;
  logic        reqStore;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  we;
  logic [31:0] drdata;
  logic [31:0] ldData;
  logic        ldValid;
  logic        stall;
  logic        fault;

  logic        memClear;
  logic [31:0] mem [32];

  int assertCount = 0;
  int failCount   = 0;

  dmem_access_unit #(.DMEM_BYTES(128)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (reqValid),
    .req_store  (reqStore),
    .req_funct3 (reqFunct3),
    .req_addr   (reqAddr),
    .req_wdata  (reqWdata),
    .daddr      (daddr),
    .dwdata     (dwdata),
    .we         (we),
    .drdata     (drdata),
    .ld_data    (ldData),
    .ld_valid   (ldValid),
    .stall      (stall),
    .fault      (fault)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational read port of the memory model. Out-of-range words read as zero.
  always_comb begin
    drdata = (daddr < 32'd128) ? mem[daddr[6:2]] : 32'h0;
  end

  // Byte-enabled write port of the memory model. memClear zeroes the array.
  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
    end else if (daddr < 32'd128) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[daddr[6:2]][8*b +: 8] <= dwdata[8*b +: 8];
      end
    end
  end

  // Drives one request onto the inputs. The caller advances time.
  task automatic applyStimulus(input logic v, input logic st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd);
    reqValid  = v;
    reqStore  = st;
    reqFunct3 = f3;
    reqAddr   = a;
    reqWdata  = wd;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; memClear = 1'b1;
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h10, 32'hFFFFFFFF);
    @(negedge clk);
    assertCount++; if (we !== 4'h0) begin failCount++; $display("[TB] FAIL reset_we got %b want 0000", we); end
    assertCount++; if (stall !== 1'b0) begin failCount++; $display("[TB] FAIL reset_stall got %b want 0", stall); end
    assertCount++; if (daddr !== 32'h0) begin failCount++; $display("[TB] FAIL reset_daddr got %h want 0", daddr); end
    assertCount++; if (dwdata !== 32'h0) begin failCount++; $display("[TB] FAIL reset_dwdata got %h want 0", dwdata); end
    assertCount++; if (ldValid !== 1'b0 || ldData !== 32'h0) begin failCount++; $display("[TB] FAIL reset_ld got %b/%h want 0/0", ldValid, ldData); end
    assertCount++; if (fault !== 1'b0) begin failCount++; $display("[TB] FAIL reset_fault got %b want 0", fault); end
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    nextCycle();
    rst = 1'b0; memClear = 1'b0;
    @(negedge clk);
    assertCount++; if (we !== 4'h0 || stall !== 1'b0 || ldValid !== 1'b0) begin failCount++; $display("[TB] FAIL idle_quiet got we=%b stall=%b ldv=%b want 0", we, stall, ldValid); end
    nextCycle();
  endtask

  task automatic test_word_store_load();
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    assertCount++; if (daddr !== 32'h10) begin failCount++; $display("[TB] FAIL sw_daddr got %h want 00000010", daddr); end
    assertCount++; if (we !== 4'b1111) begin failCount++; $display("[TB] FAIL sw_we got %b want 1111", we); end
    assertCount++; if (dwdata !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL sw_dwdata got %h want deadbeef", dwdata); end
    assertCount++; if (stall !== 1'b0 || ldValid !== 1'b0) begin failCount++; $display("[TB] FAIL sw_stall_ldv got %b/%b want 0/0", stall, ldValid); end
    nextCycle();
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    @(negedge clk);
    assertCount++; if (ldValid !== 1'b1 || ldData !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL lw_readback got %b/%h want 1/deadbeef", ldValid, ldData); end
    assertCount++; if (we !== 4'h0 || stall !== 1'b0) begin failCount++; $display("[TB] FAIL lw_we_stall got %b/%b want 0000/0", we, stall); end
    nextCycle();
  endtask

  task automatic test_byte_access();
    applyStimulus(1'b1, 1'b1, 3'b000, 32'h05, 32'h0000009A);
    @(negedge clk);
    assertCount++; if (daddr !== 32'h04 || we !== 4'b0010) begin failCount++; $display("[TB] FAIL sb_lane got %h/%b want 00000004/0010", daddr, we); end
    assertCount++; if (dwdata !== 32'h00009A00) begin failCount++; $display("[TB] FAIL sb_dwdata got %h want 00009a00", dwdata); end
    nextCycle();
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h05, 32'h0);
    @(negedge clk);
    assertCount++; if (daddr !== 32'h04) begin failCount++; $display("[TB] FAIL lbu_daddr got %h want 00000004", daddr); end
    assertCount++; if (ldValid !== 1'b1 || ldData !== 32'h0000009A) begin failCount++; $display("[TB] FAIL lbu_data got %b/%h want 1/0000009a", ldValid, ldData); end
    nextCycle();
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h05, 32'h0);
    @(negedge clk);
    assertCount++; if (ldValid !== 1'b1 || ldData !== 32'hFFFFFF9A) begin failCount++; $display("[TB] FAIL lb_data got %b/%h want 1/ffffff9a", ldValid, ldData); end
    nextCycle();
  endtask

  task automatic test_crossing_store();
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h0E, 32'h11223344);
    @(negedge clk);
    assertCount++; if (daddr !== 32'h0C || we !== 4'b1100) begin failCount++; $display("[TB] FAIL xsw_b1_lane got %h/%b want 0000000c/1100", daddr, we); end
    assertCount++; if (dwdata !== 32'h33440000 || stall !== 1'b1) begin failCount++; $display("[TB] FAIL xsw_b1_data got %h/%b want 33440000/1", dwdata, stall); end
    nextCycle();
    @(negedge clk);
    assertCount++; if (daddr !== 32'h10 || we !== 4'b0011) begin failCount++; $display("[TB] FAIL xsw_b2_lane got %h/%b want 00000010/0011", daddr, we); end
    assertCount++; if (dwdata !== 32'h00001122 || stall !== 1'b0) begin failCount++; $display("[TB] FAIL xsw_b2_data got %h/%b want 00001122/0", dwdata, stall); end
    nextCycle();
    // Back-to-back crossing LW stitches the bytes back together.
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0E, 32'h0);
    @(negedge clk);
    assertCount++; if (stall !== 1'b1 || ldValid !== 1'b0) begin failCount++; $display("[TB] FAIL xlw_b1 got stall=%b ldv=%b want 1/0", stall, ldValid); end
    nextCycle();
    @(negedge clk);
    assertCount++; if (ldValid !== 1'b1 || ldData !== 32'h11223344) begin failCount++; $display("[TB] FAIL xlw_b2 got %b/%h want 1/11223344", ldValid, ldData); end
    nextCycle();
  endtask

  task automatic test_crossing_load();
    applyStimulus(1'b1, 1'b1, 3'b000, 32'h13, 32'h00000080);
    @(negedge clk);
    assertCount++; if (we !== 4'b1000 || dwdata !== 32'h80000000) begin failCount++; $display("[TB] FAIL sb13 got %b/%h want 1000/80000000", we, dwdata); end
    nextCycle();
    applyStimulus(1'b1, 1'b1, 3'b000, 32'h14, 32'h000000FF);
    @(negedge clk);
    assertCount++; if (daddr !== 32'h14 || we !== 4'b0001) begin failCount++; $display("[TB] FAIL sb14 got %h/%b want 00000014/0001", daddr, we); end
    nextCycle();
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h13, 32'h0);
    @(negedge clk);
    assertCount++; if (stall !== 1'b1 || ldValid !== 1'b0 || daddr !== 32'h10) begin failCount++; $display("[TB] FAIL xlh_b1 got stall=%b ldv=%b daddr=%h want 1/0/00000010", stall, ldValid, daddr); end
    nextCycle();
    @(negedge clk);
    assertCount++; if (daddr !== 32'h14 || stall !== 1'b0) begin failCount++; $display("[TB] FAIL xlh_b2_addr got %h/%b want 00000014/0", daddr, stall); end
    assertCount++; if (ldValid !== 1'b1 || ldData !== 32'hFFFFFF80) begin failCount++; $display("[TB] FAIL xlh_b2_data got %b/%h want 1/ffffff80", ldValid, ldData); end
    nextCycle();
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h13, 32'h0);
    nextCycle();
    @(negedge clk);
    assertCount++; if (ldValid !== 1'b1 || ldData !== 32'h0000FF80) begin failCount++; $display("[TB] FAIL xlhu_b2_data got %b/%h want 1/0000ff80", ldValid, ldData); end
    nextCycle();
  endtask

  task automatic test_fault();
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h7E, 32'hA5A5A5A5);
    @(negedge clk);
    assertCount++; if (fault !== 1'b1) begin failCount++; $display("[TB] FAIL oob_fault got %b want 1", fault); end
    assertCount++; if (we !== 4'h0 || stall !== 1'b0) begin failCount++; $display("[TB] FAIL oob_we_stall got %b/%b want 0000/0", we, stall); end
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    assertCount++; if (fault !== 1'b0 || we !== 4'h0) begin failCount++; $display("[TB] FAIL oob_after got fault=%b we=%b want 0/0000", fault, we); end
    nextCycle();
    // The last in-range word is legal and still holds zero.
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h7C, 32'h0);
    @(negedge clk);
    assertCount++; if (fault !== 1'b0 || ldValid !== 1'b1 || ldData !== 32'h0) begin failCount++; $display("[TB] FAIL oob_unchanged got fault=%b ldv=%b data=%h want 0/1/00000000", fault, ldValid, ldData); end
    nextCycle();
    applyStimulus(1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
    @(negedge clk);
    assertCount++; if (fault !== 1'b1 || ldValid !== 1'b0) begin failCount++; $display("[TB] FAIL bad_ld_f3 got fault=%b ldv=%b want 1/0", fault, ldValid); end
    nextCycle();
    applyStimulus(1'b1, 1'b1, 3'b100, 32'h10, 32'h12345678);
    @(negedge clk);
    assertCount++; if (fault !== 1'b1 || we !== 4'h0) begin failCount++; $display("[TB] FAIL bad_st_f3 got fault=%b we=%b want 1/0000", fault, we); end
    nextCycle();
  endtask

  task automatic test_reset_in_beat2();
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h21, 32'h0);
    @(negedge clk);
    assertCount++; if (stall !== 1'b1) begin failCount++; $display("[TB] FAIL rb2_b1_stall got %b want 1", stall); end
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    assertCount++; if (we !== 4'h0 || ldValid !== 1'b0) begin failCount++; $display("[TB] FAIL rb2_during got we=%b ldv=%b want 0000/0", we, ldValid); end
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    assertCount++; if (stall !== 1'b0 || we !== 4'h0 || ldValid !== 1'b0) begin failCount++; $display("[TB] FAIL rb2_after got stall=%b we=%b ldv=%b want 0/0000/0", stall, we, ldValid); end
    nextCycle();
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    @(negedge clk);
    assertCount++; if (daddr !== 32'h20 || stall !== 1'b0) begin failCount++; $display("[TB] FAIL rb2_lw_addr got %h/%b want 00000020/0", daddr, stall); end
    assertCount++; if (ldValid !== 1'b1 || ldData !== 32'hCAFEF00D) begin failCount++; $display("[TB] FAIL rb2_lw_data got %b/%h want 1/cafef00d", ldValid, ldData); end
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    nextCycle();
  endtask

  // Runs each scenario in order and prints the summary.
  initial begin
    test_reset();
    test_word_store_load();
    test_byte_access();
    test_crossing_store();
    test_crossing_load();
    test_fault();
    test_reset_in_beat2();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
